// File: rtl/friscv_uart_dbg_pkg.sv
// Shared command/response byte values and the bridge FSM state type for the UART-to-APB
// debug bridge.
package friscv_uart_dbg_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam logic [7:0] RSP_TO  = 8'h54;

  typedef enum logic [2:0] {
    StIdle,
    StCmdChk,
    StAddr,
    StData,
    StReq,
    StWaitRdy,
    StResp
  } state_e;

endpackage

// File: rtl/friscv_uart_dbg_if.sv
// Single-transaction peripheral bus driven by the debug bridge (master) and answered by a
// peripheral responder (slave).
interface friscv_uart_dbg_if #(
  parameter int unsigned ADDRW = 16,
  parameter int unsigned XLEN  = 32
);

  logic              mst_en;
  logic              mst_wr;
  logic [ADDRW-1:0]  mst_addr;
  logic [XLEN-1:0]   mst_wdata;
  logic [XLEN/8-1:0] mst_strb;
  logic [XLEN-1:0]   mst_rdata;
  logic              mst_ready;

  modport master (
    output mst_en, mst_wr, mst_addr, mst_wdata, mst_strb,
    input  mst_rdata, mst_ready
  );

  modport slave (
    input  mst_en, mst_wr, mst_addr, mst_wdata, mst_strb,
    output mst_rdata, mst_ready
  );

endinterface

// File: rtl/friscv_uart_dbg_phy.sv
// 8N1 UART physical layer: rx synchronizer and deserializer (byte-valid pulse) and a tx
// serializer with a valid/ready byte input that supports back-to-back frames.
module friscv_uart_dbg_phy #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       srst,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       rx_st_q, rx_st_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_sr_q, rx_sr_d;
  logic            rx_valid_q, rx_valid_d;

  logic            tx_busy_q, tx_busy_d;
  logic            tx_q, tx_d;
  logic [8:0]      tx_sr_q, tx_sr_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else if (srst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_comb begin
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sr_d    = rx_sr_q;
    rx_valid_d = 1'b0;
    unique case (rx_st_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_st_d = RxStart;
      end
      RxStart: begin
        // Line back high at mid start bit: treat as a glitch.
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_st_d  = rx_sync_q ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d = '0;
          rx_sr_d  = {rx_sync_q, rx_sr_q[7:1]};
          rx_bit_d = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_st_d = RxStop;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_st_d    = RxIdle;
          rx_valid_d = rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_st_d = RxIdle;
    endcase
    if (srst) begin
      rx_st_d    = RxIdle;
      rx_cnt_d   = '0;
      rx_bit_d   = '0;
      rx_sr_d    = '0;
      rx_valid_d = 1'b0;
    end
  end

  // Ready during the last stop-bit cycle so the next start bit follows without a gap.
  assign tx_ready = !tx_busy_q || (tx_bit_q == 4'd9 && tx_cnt_q == BIT_END);

  always_comb begin
    tx_busy_d = tx_busy_q;
    tx_d      = tx_q;
    tx_sr_d   = tx_sr_q;
    tx_bit_d  = tx_bit_q;
    tx_cnt_d  = tx_cnt_q;
    if (tx_valid && tx_ready) begin
      tx_busy_d = 1'b1;
      tx_d      = 1'b0;
      tx_sr_d   = {1'b1, tx_data};
      tx_bit_d  = '0;
      tx_cnt_d  = '0;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == BIT_END) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_d = 1'b0;
        end else begin
          tx_d     = tx_sr_q[0];
          tx_sr_d  = {1'b1, tx_sr_q[8:1]};
          tx_bit_d = tx_bit_q + 1'b1;
        end
      end else begin
        tx_cnt_d = tx_cnt_q + 1'b1;
      end
    end
    if (srst) begin
      tx_busy_d = 1'b0;
      tx_d      = 1'b1;
      tx_sr_d   = '0;
      tx_bit_d  = '0;
      tx_cnt_d  = '0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rx_st_q    <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sr_q    <= '0;
      rx_valid_q <= 1'b0;
      tx_busy_q  <= 1'b0;
      tx_q       <= 1'b1;
      tx_sr_q    <= '0;
      tx_bit_q   <= '0;
      tx_cnt_q   <= '0;
    end else begin
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sr_q    <= rx_sr_d;
      rx_valid_q <= rx_valid_d;
      tx_busy_q  <= tx_busy_d;
      tx_q       <= tx_d;
      tx_sr_q    <= tx_sr_d;
      tx_bit_q   <= tx_bit_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_sr_q;
  assign uart_tx  = tx_q;

endmodule

// File: rtl/friscv_uart_dbg_bridge.sv
// UART-to-APB debug bridge: decodes 'W'/'R' command frames into single bus transactions.
// Optional bus timeout enabled by defining FRISCV_UART_DBG_TIMEOUT_EN.
module friscv_uart_dbg_bridge
  import friscv_uart_dbg_pkg::*;
#(
  parameter int unsigned ADDRW        = 16,
  parameter int unsigned XLEN         = 32,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   srst,
  input  logic                   uart_rx,
  output logic                   uart_tx,
  friscv_uart_dbg_if.master      bus
);

  localparam int unsigned ABYTES = (ADDRW + 7) / 8;
  localparam int unsigned DBYTES = XLEN / 8;
  localparam int unsigned AW     = ABYTES * 8;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [AW-1:0]     addr_sr_q, addr_sr_d;
  logic [XLEN-1:0]   data_sr_q, data_sr_d;
  logic              en_q, en_d;
  logic              wr_q, wr_d;
  logic [ADDRW-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [DBYTES-1:0] strb_q, strb_d;
  logic [XLEN-1:0]   resp_sr_q, resp_sr_d;
  logic [3:0]        resp_cnt_q, resp_cnt_d;

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;

  logic              done;
  logic [XLEN-1:0]   resp_load;
  logic [3:0]        resp_len;
  logic              to_hit;

  friscv_uart_dbg_phy #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_phy (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .srst     (srst),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

`ifdef FRISCV_UART_DBG_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      to_cnt_q <= '0;
    end else if (srst || state_q != StWaitRdy) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign to_hit = (to_cnt_q == TW'(TIMEOUT - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    addr_sr_d  = addr_sr_q;
    data_sr_d  = data_sr_q;
    en_d       = en_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    resp_sr_d  = resp_sr_q;
    resp_cnt_d = resp_cnt_q;
    tx_valid   = 1'b0;
    tx_data    = resp_sr_q[XLEN-1 -: 8];
    done       = 1'b0;
    resp_load  = '0;
    resp_len   = 4'd1;
    unique case (state_q)
      StIdle: begin
        if (rx_valid) begin
          cmd_d   = rx_data;
          state_d = StCmdChk;
        end
      end
      StCmdChk: begin
        cnt_d = '0;
        if (cmd_q == CMD_WR || cmd_q == CMD_RD) begin
          state_d = StAddr;
        end else begin
          resp_sr_d  = XLEN'(RSP_ERR) << (XLEN - 8);
          resp_cnt_d = 4'd1;
          state_d    = StResp;
        end
      end
      StAddr: begin
        if (rx_valid) begin
          addr_sr_d = (addr_sr_q << 8) | AW'(rx_data);
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == 4'(ABYTES - 1)) begin
            cnt_d   = '0;
            state_d = (cmd_q == CMD_WR) ? StData : StReq;
          end
        end
      end
      StData: begin
        if (rx_valid) begin
          data_sr_d = (data_sr_q << 8) | XLEN'(rx_data);
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == 4'(DBYTES - 1)) begin
            cnt_d   = '0;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        en_d    = 1'b1;
        wr_d    = (cmd_q == CMD_WR);
        addr_d  = addr_sr_q[ADDRW-1:0];
        wdata_d = data_sr_q;
        strb_d  = (cmd_q == CMD_WR) ? '1 : '0;
        state_d = StWaitRdy;
      end
      StWaitRdy: begin
        // Ready in the expiry cycle takes precedence over the timeout.
        if (bus.mst_ready) begin
          done      = 1'b1;
          resp_load = wr_q ? (XLEN'(RSP_OK) << (XLEN - 8)) : bus.mst_rdata;
          resp_len  = wr_q ? 4'd1 : 4'(DBYTES);
        end else if (to_hit) begin
          done      = 1'b1;
          resp_load = XLEN'(RSP_TO) << (XLEN - 8);
          resp_len  = 4'd1;
        end
        if (done) begin
          en_d     = 1'b0;
          strb_d   = '0;
          tx_valid = 1'b1;
          tx_data  = resp_load[XLEN-1 -: 8];
          // First response byte launches in the same cycle mst_en drops.
          if (tx_ready) begin
            resp_sr_d  = resp_load << 8;
            resp_cnt_d = resp_len - 1'b1;
            state_d    = (resp_len == 4'd1) ? StIdle : StResp;
          end else begin
            resp_sr_d  = resp_load;
            resp_cnt_d = resp_len;
            state_d    = StResp;
          end
        end
      end
      StResp: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          resp_sr_d  = resp_sr_q << 8;
          resp_cnt_d = resp_cnt_q - 1'b1;
          if (resp_cnt_q == 4'd1) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (srst) begin
      state_d    = StIdle;
      cnt_d      = '0;
      cmd_d      = '0;
      addr_sr_d  = '0;
      data_sr_d  = '0;
      en_d       = 1'b0;
      wr_d       = 1'b0;
      addr_d     = '0;
      wdata_d    = '0;
      strb_d     = '0;
      resp_sr_d  = '0;
      resp_cnt_d = '0;
      tx_valid   = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      cmd_q      <= '0;
      addr_sr_q  <= '0;
      data_sr_q  <= '0;
      en_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      resp_sr_q  <= '0;
      resp_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      addr_sr_q  <= addr_sr_d;
      data_sr_q  <= data_sr_d;
      en_q       <= en_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      resp_sr_q  <= resp_sr_d;
      resp_cnt_q <= resp_cnt_d;
    end
  end

  assign bus.mst_en    = en_q;
  assign bus.mst_wr    = wr_q;
  assign bus.mst_addr  = addr_q;
  assign bus.mst_wdata = wdata_q;
  assign bus.mst_strb  = strb_q;

endmodule

// File: tb/tb_friscv_uart_dbg_bridge.sv
// Randomized bench for the UART debug bridge: frames are scored against a byte-level model
// of the command protocol, with a responder model on the bus and a UART decoder on uart_tx.
module tb_friscv_uart_dbg_bridge;

  localparam int unsigned CLKS = 16;
  localparam int unsigned TO   = 64;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } txn_t;

  logic aclk = 1'b0;
  logic aresetn;
  logic srst;
  logic uart_rx;
  logic uart_tx;

  friscv_uart_dbg_if #(.ADDRW(16), .XLEN(32)) bus ();

  friscv_uart_dbg_bridge #(
    .ADDRW        (16),
    .XLEN         (32),
    .CLKS_PER_BIT (CLKS),
    .TIMEOUT      (TO)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .srst    (srst),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .bus     (bus)
  );

  always #5 aclk = ~aclk;

  txn_t        txq[$];
  logic [7:0]  rxq[$];
  logic [7:0]  frame[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          slave_hold = 1'b0;
  logic [31:0] rd_val = '0;
  int          en_hi = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic txn_t bus_now();
    return {bus.mst_wr, bus.mst_addr, bus.mst_wdata, bus.mst_strb};
  endfunction

  // Bus responder: random wait states, or holds off indefinitely while slave_hold is set.
  initial begin : slave
    txn_t cap;
    int   ws;
    bus.mst_ready = 1'b0;
    bus.mst_rdata = '0;
    forever begin
      @(posedge aclk); #1;
      if (bus.mst_en === 1'b1) begin
        cap = bus_now();
        txq.push_back(cap);
        ws = $urandom_range(0, 3);
        for (int k = 0; k < ws || slave_hold; k++) begin
          @(posedge aclk); #1;
          if (bus.mst_en !== 1'b1) break;
          check_eq("bus_stable", 64'(bus_now()), 64'(cap));
        end
        if (bus.mst_en === 1'b1) begin
          bus.mst_rdata = rd_val;
          bus.mst_ready = 1'b1;
          @(posedge aclk); #1;
          bus.mst_ready = 1'b0;
          bus.mst_rdata = $urandom;
          check_eq("en_drop", 64'(bus.mst_en), 64'd0);
        end
      end
    end
  end

  initial begin : en_count
    forever begin
      @(posedge aclk); #1;
      if (bus.mst_en === 1'b1) en_hi++;
    end
  end

  // UART decoder on uart_tx, sampling at bit centres.
  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge aclk);
      if (aresetn === 1'b1 && uart_tx === 1'b0) begin
        repeat (CLKS / 2) @(negedge aclk);
        for (int i = 0; i < 8; i++) begin
          repeat (CLKS) @(negedge aclk);
          b[i] = uart_tx;
        end
        repeat (CLKS) @(negedge aclk);
        check_eq("tx_stop", 64'(uart_tx), 64'd1);
        rxq.push_back(b);
      end
    end
  end

  initial begin : watchdog
    repeat (95000) @(posedge aclk);
    $display("FAIL watchdog: got no finish, expected finish within budget");
    $fatal(1, "simulation budget exhausted");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = bits[i];
      repeat (CLKS) @(negedge aclk);
    end
  endtask

  task automatic send_frame();
    foreach (frame[i]) send_byte(frame[i], 1'b1);
    uart_rx = 1'b1;
  endtask

  task automatic set_w(input logic [15:0] a, input logic [31:0] d);
    frame.delete();
    frame.push_back(8'h57);
    frame.push_back(a[15:8]);
    frame.push_back(a[7:0]);
    for (int i = 3; i >= 0; i--) frame.push_back(8'(d >> (8 * i)));
  endtask

  task automatic set_r(input logic [15:0] a);
    frame.delete();
    frame.push_back(8'h52);
    frame.push_back(a[15:8]);
    frame.push_back(a[7:0]);
  endtask

  task automatic set_cmd(input logic [7:0] c);
    frame.delete();
    frame.push_back(c);
  endtask

  task automatic wait_resp(input int n);
    for (int c = 0; c < 100 * CLKS && rxq.size() < n; c++) @(negedge aclk);
    check_eq("resp_arrived", 64'(rxq.size() >= n), 64'd1);
  endtask

  // Reference: protocol-level expectation for the frame currently in 'frame'.
  task automatic run_frame(input logic [31:0] rd);
    logic [7:0] exp_resp[$];
    bit         exp_txn;
    txn_t       exp_t;
    exp_txn = 1'b0;
    exp_t   = '0;
    rd_val  = rd;
    rxq.delete();
    txq.delete();
    if (frame[0] == 8'h57 && frame.size() == 7) begin
      exp_txn     = 1'b1;
      exp_t.wr    = 1'b1;
      exp_t.addr  = 16'(frame[1] * 256 + frame[2]);
      exp_t.wdata = 32'(((frame[3] * 256 + frame[4]) * 256 + frame[5]) * 256 + frame[6]);
      exp_t.strb  = 4'hF;
      exp_resp.push_back(8'h4B);
    end else if (frame[0] == 8'h52 && frame.size() == 3) begin
      exp_txn    = 1'b1;
      exp_t.addr = 16'(frame[1] * 256 + frame[2]);
      for (int i = 3; i >= 0; i--) exp_resp.push_back(8'(rd >> (8 * i)));
    end else begin
      exp_resp.push_back(8'h45);
    end
    send_frame();
    wait_resp(exp_resp.size());
    repeat (12 * CLKS) @(negedge aclk);
    check_eq("resp_len", 64'(rxq.size()), 64'(exp_resp.size()));
    foreach (exp_resp[i])
      if (i < rxq.size()) check_eq($sformatf("resp_byte%0d", i), 64'(rxq[i]), 64'(exp_resp[i]));
    check_eq("txn_count", 64'(txq.size()), 64'(exp_txn));
    if (exp_txn && txq.size() != 0) begin
      check_eq("txn_wr", 64'(txq[0].wr), 64'(exp_t.wr));
      check_eq("txn_addr", 64'(txq[0].addr), 64'(exp_t.addr));
      check_eq("txn_strb", 64'(txq[0].strb), 64'(exp_t.strb));
      if (exp_t.wr) check_eq("txn_wdata", 64'(txq[0].wdata), 64'(exp_t.wdata));
    end
  endtask

  initial begin : main
    logic [7:0] c;
    aresetn = 1'b0;
    srst    = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge aclk);
    check_eq("rst_tx", 64'(uart_tx), 64'd1);
    check_eq("rst_en", 64'(bus.mst_en), 64'd0);
    check_eq("rst_wr", 64'(bus.mst_wr), 64'd0);
    check_eq("rst_addr", 64'(bus.mst_addr), 64'd0);
    check_eq("rst_wdata", 64'(bus.mst_wdata), 64'd0);
    check_eq("rst_strb", 64'(bus.mst_strb), 64'd0);
    aresetn = 1'b1;
    repeat (4) @(negedge aclk);

    set_w(16'h0010, 32'hDEADBEEF);
    run_frame(32'h0);
    set_r(16'h1234);
    run_frame(32'hCAFEF00D);
    set_cmd(8'h41);
    run_frame(32'h0);
    set_r(16'hABCD);
    run_frame($urandom);

    // Framing error on a would-be 'W' byte must be dropped silently.
    send_byte(8'h57, 1'b0);
    uart_rx = 1'b1;
    repeat (2 * CLKS) @(negedge aclk);
    set_w(16'h0204, 32'h01234567);
    run_frame(32'h0);

    // Short low glitch shorter than half a bit.
    uart_rx = 1'b0;
    repeat (3) @(negedge aclk);
    uart_rx = 1'b1;
    repeat (2 * CLKS) @(negedge aclk);
    set_r(16'h8001);
    run_frame($urandom);

    for (int n = 0; n < 12; n++) begin
      case ($urandom_range(0, 2))
        0: set_w(16'($urandom), $urandom);
        1: set_r(16'($urandom));
        default: begin
          do c = 8'($urandom); while (c == 8'h57 || c == 8'h52);
          set_cmd(c);
        end
      endcase
      run_frame($urandom);
    end

`ifdef FRISCV_UART_DBG_TIMEOUT_EN
    slave_hold = 1'b1;
    set_r(16'h0F0F);
    rxq.delete();
    en_hi = 0;
    send_frame();
    wait_resp(1);
    repeat (12 * CLKS) @(negedge aclk);
    check_eq("to_en_cycles", 64'(en_hi), 64'(TO));
    check_eq("to_resp_len", 64'(rxq.size()), 64'd1);
    if (rxq.size() != 0) check_eq("to_resp", 64'(rxq[0]), 64'h54);
    slave_hold = 1'b0;
`endif

    // Asynchronous reset while the bus is waiting.
    slave_hold = 1'b1;
    set_r(16'h5A5A);
    send_frame();
    repeat (4) @(negedge aclk);
    check_eq("arst_pre_en", 64'(bus.mst_en), 64'd1);
    aresetn = 1'b0;
    #1;
    check_eq("arst_en", 64'(bus.mst_en), 64'd0);
    check_eq("arst_tx", 64'(uart_tx), 64'd1);
    check_eq("arst_addr", 64'(bus.mst_addr), 64'd0);
    check_eq("arst_strb", 64'(bus.mst_strb), 64'd0);
    @(negedge aclk);
    aresetn    = 1'b1;
    slave_hold = 1'b0;
    repeat (4) @(negedge aclk);
    set_w(16'h3344, $urandom);
    run_frame(32'h0);

    // Synchronous reset while the bus is waiting.
    slave_hold = 1'b1;
    set_w(16'h7788, 32'h55AA55AA);
    send_frame();
    repeat (4) @(negedge aclk);
    check_eq("srst_pre_en", 64'(bus.mst_en), 64'd1);
    srst = 1'b1;
    @(posedge aclk); #1;
    check_eq("srst_en", 64'(bus.mst_en), 64'd0);
    check_eq("srst_tx", 64'(uart_tx), 64'd1);
    @(negedge aclk);
    srst       = 1'b0;
    slave_hold = 1'b0;
    repeat (4) @(negedge aclk);
    set_r(16'h0042);
    run_frame($urandom);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/friscv_uart_dbg_bridge.md
# friscv_uart_dbg_bridge

UART-to-APB debug bridge: deserializes 8N1 command frames from a host on `uart_rx` and issues single APB-style transactions as bus initiator. It returns acknowledgements or read data on `uart_tx`. It is the master-side counterpart of the UART/APB peripheral responder and gives a host direct access to the same `mst_*` peripheral bus.

## Interface
- `ADDRW`, 16: bus address width; address bytes on the wire = ceil(ADDRW/8).
- `XLEN`, 32: bus data width; data bytes on the wire = XLEN/8.
- `CLKS_PER_BIT`, 868: aclk cycles per UART bit (100 MHz / 115200); must be ≥ 8.
- `TIMEOUT`, 1024: cycles waited for `mst_ready` (timeout build only).
- `aclk` in 1: clock.
- `aresetn` in 1: reset, asynchronous, active-low.
- `srst` in 1: synchronous reset, active-high, same effect as `aresetn`.
- `mst_en` out 1: transaction request.
- `mst_wr` out 1: 1 = write, 0 = read.
- `mst_addr` out ADDRW: address.
- `mst_wdata` out XLEN: write data.
- `mst_strb` out XLEN/8: byte strobes, all ones during writes, zero otherwise.
- `mst_rdata` in XLEN: read data, valid when `mst_ready`=1.
- `mst_ready` in 1: slave completion, one-cycle pulse.
- `uart_rx` in 1: serial input, asynchronous, idle high.
- `uart_tx` out 1: serial output, idle high.

## Operation
- Reset values: `uart_tx`=1, `mst_en`=0, `mst_wr`=0, `mst_addr`=0, `mst_wdata`=0, `mst_strb`=0. FSM returns to IDLE and both shifters clear.
- Wire format: 8N1, LSB first. Multi-byte fields are sent MSB first. Address bits above ADDRW are discarded.
- Command byte `0x57` ('W') is followed by the address bytes, then the data bytes. The bridge performs a bus write and responds with `0x4B` ('K').
- Command byte `0x52` ('R') is followed by the address bytes. The bridge performs a bus read and responds with the XLEN/8 data bytes, MSB first.
- Any other command byte gets the response `0x45` ('E'); the bridge then returns to IDLE.
- Receive path:
  - `uart_rx` passes through a 2-flop synchronizer.
  - A falling edge in idle starts a bit counter. The start bit is re-checked at CLKS_PER_BIT/2; if it is high, the event is a glitch and is ignored.
  - Data bits are sampled at bit centres.
  - A stop bit sampled at 0 is a framing error: the byte is dropped and the FSM returns to IDLE with no response.
- Transmit path: start bit, 8 data bits, stop bit, with each bit held CLKS_PER_BIT cycles. Back-to-back bytes have no extra gap.
- FSM states:
  - IDLE → CMD_CHK on a received byte.
  - CMD_CHK → ADDR (W/R) or RESP (E).
  - ADDR (byte counter) → DATA (W) or REQ (R).
  - DATA (byte counter) → REQ.
  - REQ: assert `mst_en` with addr/wr/wdata/strb → WAIT_RDY.
  - WAIT_RDY: on `mst_ready`, capture `mst_rdata` (read) and deassert `mst_en` on the next edge → RESP.
  - RESP: send the response byte(s) → IDLE.
- Bus handshake:
  - `mst_en`, `mst_addr`, `mst_wr`, `mst_wdata` and `mst_strb` stay stable from assertion until the cycle `mst_ready` is sampled high.
  - `mst_en` is low the cycle after that; only one transaction is outstanding.
- Bytes received while the FSM is in REQ, WAIT_RDY or RESP are discarded.

## Timing
- REQ → `mst_en` high: 1 cycle after the last frame byte's stop-bit sample.
- `mst_ready` → `mst_en` low: 1 cycle. The first response start bit begins in the same cycle.
- Round-trip latency with a 1-wait-state slave: frame time + 2 cycles + response time.
- `mst_ready` while `mst_en`=0 is ignored.
- `srst` or `aresetn` mid-transaction: `mst_en` drops immediately (asynchronously for `aresetn`, next edge for `srst`); `uart_tx` returns high even mid-byte.

## Configuration
- `FRISCV_UART_DBG_TIMEOUT_EN` defined:
  - A counter starts at REQ.
  - If `mst_ready` has not arrived after TIMEOUT cycles, `mst_en` drops and the response byte is `0x54` ('T').
  - For reads, no data bytes follow the timeout response.
  - `mst_ready` arriving in the same cycle as expiry wins: the transaction completes normally.
- Not defined: WAIT_RDY waits indefinitely and the TIMEOUT parameter is unused.

## Structure
- `friscv_uart_dbg_pkg` holds:
  - command and response byte constants: CMD_WR, CMD_RD, RSP_OK, RSP_ERR, RSP_TO;
  - the FSM state enum typedef.
- Sub-module `friscv_uart_dbg_phy` contains the synchronizer, RX deserializer and TX serializer.
  - RX side: byte-valid pulse.
  - TX side: valid/ready byte input.
- The top level contains the FSM, the field shift registers and the bus driver.

## Test plan
- Send 'W',0x00,0x10,0xDE,0xAD,0xBE,0xEF → one `mst_en` pulse with `mst_wr`=1, addr 0x0010, wdata 0xDEADBEEF, strb 0xF; TX returns 0x4B.
- Send 'R',0x12,0x34 with the slave returning 0xCAFEF00D → `mst_wr`=0, addr 0x1234; TX returns 0xCA,0xFE,0xF0,0x0D.
- Send command 0x41 → no `mst_en`; TX returns 0x45; a following valid 'R' frame works.
- Send a byte with stop bit 0, then a valid 'W' frame → first byte dropped silently; the write completes with 0x4B.
- With the macro defined and the slave holding `mst_ready`=0 → `mst_en` high exactly TIMEOUT cycles, then low; TX returns 0x54.
- Assert `aresetn` low during WAIT_RDY → `mst_en`=0 and `uart_tx`=1 immediately; the next frame is processed from IDLE.
